// File: rtl/fpu_channel_mux.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_channel_mux
//  Purpose  : Shares one pipelined FPU among NUM_CH requester channels.
//             Round-robin issue with a grant lock while the FPU back-pressures,
//             per-channel credit counters, and per-channel response FIFOs
//             steered by the completion tag.
//  Options  : FPU_CHANNEL_MUX_STATS_EN adds saturating issue/stall counters.
//  Revision : 1.0  initial release
// ============================================================================
module fpu_channel_mux #(
  parameter int NUM_CH    = 4,
  parameter int FLEN      = 16,
  parameter int CMD_W     = 16,
  parameter int RSP_DEPTH = 4,
  localparam int TAG_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_CH-1:0]          ch_valid_i,
  output logic [NUM_CH-1:0]          ch_ready_o,
  input  logic [NUM_CH*CMD_W-1:0]    ch_cmd_i,
  input  logic [NUM_CH*3*FLEN-1:0]   ch_operands_i,
  output logic [NUM_CH-1:0]          ch_rvalid_o,
  input  logic [NUM_CH-1:0]          ch_rready_i,
  output logic [NUM_CH*FLEN-1:0]     ch_result_o,
  output logic [NUM_CH*5-1:0]        ch_status_o,
  output logic                       fpu_in_valid_o,
  input  logic                       fpu_in_ready_i,
  output logic [CMD_W-1:0]           fpu_cmd_o,
  output logic [3*FLEN-1:0]          fpu_operands_o,
  output logic [TAG_W-1:0]           fpu_tag_o,
  input  logic                       fpu_out_valid_i,
  input  logic [FLEN-1:0]            fpu_result_i,
  input  logic [4:0]                 fpu_status_i,
  input  logic [TAG_W-1:0]           fpu_tag_i,
  output logic                       fpu_out_ready_o,
  output logic                       busy_o,
  output logic                       err_o
`ifdef FPU_CHANNEL_MUX_STATS_EN
  ,
  output logic [31:0]                stat_issue_o,
  output logic [31:0]                stat_stall_o
`endif
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int ENT_W = FLEN + 5;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  logic [CNT_W-1:0]  cnt    [NUM_CH];
  logic [CNT_W-1:0]  occ    [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];

  logic [TAG_W-1:0]  rr_ptr;
  logic [TAG_W-1:0]  lock_ch;
  logic [TAG_W-1:0]  grant_idx;
  logic              lock;
  logic              any_elig;
  logic              issue;
  logic              tag_bad;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  assign fpu_out_ready_o = 1'b1;

  // A channel may request only while it still holds a response credit
  always_comb begin
    eligible = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      eligible[c] = !rst_i && ch_valid_i[c] && (cnt[c] < DEPTH_C);
    end
  end

  // Round-robin search from rr_ptr; a pending handshake keeps its channel
  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = '0;
    any_elig  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any_elig && eligible[idx]) begin
        any_elig  = 1'b1;
        grant_idx = TAG_W'(idx);
      end
    end
    if (lock && eligible[lock_ch]) begin
      any_elig  = 1'b1;
      grant_idx = lock_ch;
    end
  end

  assign fpu_in_valid_o = any_elig;
  assign issue          = any_elig && fpu_in_ready_i;
  assign fpu_tag_o      = grant_idx;

  // Steer the granted channel's command and operands onto the FPU port
  always_comb begin
    fpu_cmd_o      = '0;
    fpu_operands_o = '0;
    ch_ready_o     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (any_elig && (grant_idx == TAG_W'(c))) begin
        fpu_cmd_o      = ch_cmd_i[c*CMD_W +: CMD_W];
        fpu_operands_o = ch_operands_i[c*3*FLEN +: 3*FLEN];
        ch_ready_o[c]  = fpu_in_ready_i;
      end
    end
  end

  // Completion decode: accept only for a channel with outstanding credit
  always_comb begin
    logic accepted;
    accepted = 1'b0;
    pop      = '0;
    push     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c] = (occ[c] != '0) && ch_rready_i[c];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (fpu_out_valid_i && !rst_i && (fpu_tag_i == TAG_W'(c)) && (cnt[c] != '0)) begin
        accepted = 1'b1;
        // A full FIFO can only take a new entry when its head leaves this cycle
        push[c]  = (occ[c] != DEPTH_C) || pop[c];
      end
    end
    tag_bad = fpu_out_valid_i && !rst_i && !accepted;
  end

  // Responses pending anywhere keep the block busy
  always_comb begin
    busy_o = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cnt[c] != '0) busy_o = 1'b1;
    end
  end

  // Arbiter pointer, grant lock and sticky error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr  <= '0;
      lock    <= 1'b0;
      lock_ch <= '0;
      err_o   <= 1'b0;
    end else begin
      lock    <= any_elig && !fpu_in_ready_i;
      lock_ch <= grant_idx;
      if (issue) begin
        rr_ptr <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
      end
      if (tag_bad) err_o <= 1'b1;
    end
  end

  // Per-channel credit counters and FIFO bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c]    <= '0;
        occ[c]    <= '0;
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_ready_o[c] && !pop[c]) begin
          cnt[c] <= cnt[c] + 1'b1;
        end else if (!ch_ready_o[c] && pop[c] && (cnt[c] != '0)) begin
          cnt[c] <= cnt[c] - 1'b1;
        end
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        if (push[c] && !pop[c]) begin
          occ[c] <= occ[c] + 1'b1;
        end else if (!push[c] && pop[c]) begin
          occ[c] <= occ[c] - 1'b1;
        end
      end
    end
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [ENT_W-1:0] mem [RSP_DEPTH];
      logic [ENT_W-1:0] head;

      // Response storage; the head entry is shown combinationally
      always_ff @(posedge clk_i) begin
        if (push[c]) mem[wr_ptr[c]] <= {fpu_status_i, fpu_result_i};
      end

      assign head                       = mem[rd_ptr[c]];
      assign ch_rvalid_o[c]             = (occ[c] != '0);
      assign ch_result_o[c*FLEN +: FLEN] = head[FLEN-1:0];
      assign ch_status_o[c*5 +: 5]      = head[ENT_W-1:FLEN];
    end
  endgenerate

`ifdef FPU_CHANNEL_MUX_STATS_EN
  // Saturating issue and FPU stall counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_issue_o <= '0;
      stat_stall_o <= '0;
    end else begin
      if (issue && (stat_issue_o != 32'hFFFF_FFFF)) begin
        stat_issue_o <= stat_issue_o + 32'd1;
      end
      if (any_elig && !fpu_in_ready_i && (stat_stall_o != 32'hFFFF_FFFF)) begin
        stat_stall_o <= stat_stall_o + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/fpu_channel_mux.md
FPU_CHANNEL_MUX -- requirements
Module: fpu_channel_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent requester channels (2..16).
REQ-002 SHALL have parameter FLEN, default 16: operand and result width in bits.
REQ-003 SHALL have parameter CMD_W, default 16: opaque command width (op, mod, rnd, fmt packed by requester), passed through unchanged.
REQ-004 SHALL have parameter RSP_DEPTH, default 4: per-channel response FIFO depth and per-channel credit limit (power of 2, >=2).
REQ-005 SHALL derive TAG_W = max(1, clog2(NUM_CH)); the FPU tag carries the issuing channel index.
REQ-006 Ports (name  direction  width  meaning):
- clk_i  in  1  single clock; synchronous, active-high reset; all state on rising edge.
- rst_i  in  1  synchronous active-high reset.
- ch_valid_i  in  NUM_CH  per-channel request valid.
- ch_ready_o  out  NUM_CH  per-channel request accept.
- ch_cmd_i  in  NUM_CH*CMD_W  per-channel command.
- ch_operands_i  in  NUM_CH*3*FLEN  per-channel operands a,b,c.
- ch_rvalid_o  out  NUM_CH  per-channel response valid.
- ch_rready_i  in  NUM_CH  per-channel response accept.
- ch_result_o  out  NUM_CH*FLEN  per-channel result (FIFO head).
- ch_status_o  out  NUM_CH*5  per-channel IEEE flags {NV,DZ,OF,UF,NX}.
- fpu_in_valid_o / fpu_in_ready_i  out/in  1  issue handshake to pipelined FPU.
- fpu_cmd_o  out  CMD_W; fpu_operands_o  out  3*FLEN; fpu_tag_o  out  TAG_W.
- fpu_out_valid_i  in  1; fpu_result_i  in  FLEN; fpu_status_i  in  5; fpu_tag_i  in  TAG_W  FPU completion.
- fpu_out_ready_o  out  1  constant 1.
- busy_o  out  1  any channel count nonzero.
- err_o  out  1  sticky: completion for channel with zero count, or tag >= NUM_CH.

Function
REQ-007 SHALL keep per-channel count cnt[c] (0..RSP_DEPTH) = issued-not-popped ops; +1 on issue from c, -1 on ch_rvalid_o[c]&&ch_rready_i[c]; both same cycle: unchanged.
REQ-008 Channel c eligible iff ch_valid_i[c] && cnt[c] < RSP_DEPTH.
REQ-009 Round-robin arbiter: priority starts at rr_ptr; grant = first eligible at or after it; fpu_in_valid_o = any eligible; cmd/operands/tag from granted channel, combinationally.
REQ-010 Grant SHALL be held (locked) while fpu_in_valid_o && !fpu_in_ready_i; no channel switch mid-handshake.
REQ-011 ch_ready_o[c] = granted[c] && fpu_in_ready_i; on issue rr_ptr <= (c+1) mod NUM_CH.
REQ-012 On fpu_out_valid_i with valid tag and cnt[tag]>0, result+status SHALL push into FIFO[tag]; ch_rvalid_o visible next cycle (1-cycle latency). Credit guarantees no overflow.
REQ-013 Completion with cnt[tag]==0 or tag>=NUM_CH SHALL be dropped and set err_o.
REQ-014 FIFO push and pop same cycle, including when full or empty-with-push, SHALL both take effect; order per channel preserved (FPU in-order assumed per channel).
REQ-015 Responses of one channel SHALL never stall another channel's issue or drain.

Reset
REQ-016 On rst_i: all cnt=0, FIFOs empty, rr_ptr=0, err_o=0, lock cleared; outputs ch_ready_o=0, ch_rvalid_o=0, fpu_in_valid_o=0, busy_o=0, fpu_out_ready_o=1.
REQ-017 Completions arriving during rst_i SHALL be ignored; stale completions after reset set err_o per REQ-013.

Configuration
REQ-018 Macro FPU_CHANNEL_MUX_STATS_EN: when defined, adds outputs stat_issue_o (32b, issued-op count) and stat_stall_o (32b, cycles fpu_in_valid_o && !fpu_in_ready_i), saturating, cleared by reset; when undefined, ports and counters absent, behaviour otherwise identical.

Verification
REQ-019 All 4 channels valid, fpu_in_ready_i=1 -> issues in order 0,1,2,3,0 on consecutive cycles, fpu_tag_o matches.
REQ-020 Ch1 valid, fpu_in_ready_i low 3 cycles, ch2 raises valid mid-stall -> grant stays on ch1, ch1 issues cycle 4, ch2 next.
REQ-021 Ch0 issues 4 ops, ch_rready_i[0]=0, FPU returns all -> 5th request stalls (ch_ready_o[0]=0) while ch3 still issues; one pop -> ch0 issues next cycle.
REQ-022 Completion tag=2 with cnt[2]=0 -> dropped, err_o=1 held until reset.
REQ-023 FIFO full at depth 4, pop and push same cycle -> occupancy stays 4, head advances, data order intact.
REQ-024 Reset asserted with 3 ops in flight -> all outputs at reset values next cycle; late completion -> err_o=1; with STATS_EN, stat_issue_o=0 after reset.
